// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus cycle engine.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_SETUP,
        S_ADDR_STROBE,
        S_ADDR_HOLD,
        S_DATA_SETUP,
        S_DATA_STROBE,
        S_DATA_HOLD,
        S_DONE
    } state_t;

    localparam int T_SETUP_DEF  = 2;
    localparam int T_STROBE_DEF = 4;
    localparam int T_HOLD_DEF   = 2;
    localparam int CNT_W_DEF    = 8;

    localparam logic CMD_RD = 1'b1;
    localparam logic CMD_WR = 1'b0;

    localparam logic AD_SEL_ADDR = 1'b0;
    localparam logic AD_SEL_DATA = 1'b1;

endpackage

// File: rtl/rtc_phase_timer.sv
// Down-counter that reloads on state entry; o_tc marks the final
// cycle of the current dwell.
module rtc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/rtc_bus_ctrl.sv
// RTC multiplexed address/data bus engine: one command per handshake,
// address phase then data phase, with registered pin outputs.
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_STROBE = T_STROBE_DEF,
    parameter int T_HOLD   = T_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rd_wr,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    state_t           r_state;
    state_t           w_next;
    logic             r_rw;
    logic [7:0]       r_addr;
    logic [7:0]       r_data;
    logic             w_accept;
    logic             w_rw;
    logic [7:0]       w_addr;
    logic [7:0]       w_data;
    logic             w_tc;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cs_n;
    logic             w_rd_n;
    logic             w_wr_n;
    logic             w_a_d;
    logic             w_ad_oe;
    logic [7:0]       w_ad_out;

    // Pins are registered from the next state, so the command being
    // accepted this edge must bypass the latches.
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_rw     = w_accept ? rd_wr   : r_rw;
    assign w_addr   = w_accept ? address : r_addr;
    assign w_data   = w_accept ? data_in : r_data;
    assign w_load   = (w_next != r_state);

    rtc_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_tc      (w_tc)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:        if (start) w_next = S_ADDR_SETUP;
            S_ADDR_SETUP:  if (w_tc)  w_next = S_ADDR_STROBE;
            S_ADDR_STROBE: if (w_tc)  w_next = S_ADDR_HOLD;
            S_ADDR_HOLD:   if (w_tc)  w_next = S_DATA_SETUP;
            S_DATA_SETUP:  if (w_tc)  w_next = S_DATA_STROBE;
            S_DATA_STROBE: if (w_tc)  w_next = S_DATA_HOLD;
            S_DATA_HOLD:   if (w_tc)  w_next = S_DONE;
            S_DONE:                   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_val = '0;
        unique case (w_next)
            S_ADDR_SETUP,  S_DATA_SETUP:  w_load_val = CNT_W'(T_SETUP);
            S_ADDR_STROBE, S_DATA_STROBE: w_load_val = CNT_W'(T_STROBE);
            S_ADDR_HOLD,   S_DATA_HOLD:   w_load_val = CNT_W'(T_HOLD);
            S_DONE:                       w_load_val = CNT_W'(1);
            default:                      w_load_val = '0;
        endcase
    end

    always_comb begin
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_a_d    = AD_SEL_DATA;
        w_ad_oe  = 1'b0;
        w_ad_out = '0;
        unique case (w_next)
            S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD: begin
                w_cs_n   = 1'b0;
                w_a_d    = AD_SEL_ADDR;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr;
                w_wr_n   = (w_next != S_ADDR_STROBE);
            end
            S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD: begin
                w_cs_n = 1'b0;
                if (w_rw == CMD_RD) begin
                    w_rd_n = (w_next != S_DATA_STROBE);
                end else begin
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_data;
                    w_wr_n   = (w_next != S_DATA_STROBE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_d     <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
        end else begin
            if (w_accept) begin
                r_rw   <= rd_wr;
                r_addr <= address;
                r_data <= data_in;
            end
            cs_n   <= w_cs_n;
            rd_n   <= w_rd_n;
            wr_n   <= w_wr_n;
            a_d    <= w_a_d;
            ad_oe  <= w_ad_oe;
            ad_out <= w_ad_out;
            ready  <= (w_next == S_IDLE);
            busy   <= (w_next != S_IDLE);
            done   <= (w_next == S_DONE);
            // Capture on the last strobe cycle, while rd_n is still low.
            if (r_state == S_DATA_STROBE && w_tc && r_rw == CMD_RD) begin
                rd_data <= ad_in;
            end
        end
    end

endmodule
